nios_system_pio_gen2: RTL and testbench

NIOS_SYSTEM_PIO_GEN2 -- requirements
Module: nios_system_pio_gen2

---
 rtl/nios_pio_pkg.sv | 51 +++++
 rtl/nios_pio_edge_sync.sv | 60 ++++++
 rtl/nios_system_pio_gen2.sv | 151 +++++++++++++++
 tb/tb_nios_system_pio_gen2.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Avalon-MM parallel I/O block.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: register word addresses, capture-edge and IRQ-source encodings,
// the decoded bus request struct and a per-bit edge classifier.

package nios_pio_pkg;

  // Register word addresses. Addresses 6 and 7 are reserved.
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  // Capture edge encodings (EDGE_TYPE parameter).
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Interrupt source encodings (IRQ_TYPE parameter).
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  // Cycles after reset release during which the edge detector only loads
  // its history. This covers the two synchroniser stages plus the history
  // stage, so a pin that is already high is not seen as a 0->1 edge.
  localparam int ARM_CYCLES = 3;

  // One bus access, decoded from the Avalon-MM strobes.
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [2:0] addr;
  } bus_req_t;

  // Classifies one bit transition against the configured edge type.
  function automatic logic edge_bit(input logic cur, input logic prev,
                                    input int edge_type);
    logic hit;
    case (edge_type)
      EDGE_RISING:  hit = cur & ~prev;
      EDGE_FALLING: hit = ~cur & prev;
      default:      hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/nios_pio_edge_sync.sv
// Pin synchroniser and edge detector for the parallel I/O block.
// Latency: pin -> sync_in 2 clk; sync_in change -> edge_det same cycle (combinational).
// Backpressure: none; pins are sampled every cycle.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : asynchronous pin inputs
//   sync_in      : in_port after the 2-flop synchroniser
//   edge_det     : one-cycle pulse per bit when sync_in shows an edge of EDGE_TYPE

module nios_pio_edge_sync
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hist_q;
  logic [1:0]       arm_cnt_q;
  logic             armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      hist_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      meta_q <= in_port;
      sync_q <= meta_q;
      hist_q <= sync_q;
      // Saturating arm counter: history loads freely until it reaches ARM_CYCLES.
      if (arm_cnt_q != 2'(ARM_CYCLES)) begin
        arm_cnt_q <= arm_cnt_q + 2'd1;
      end
    end
  end

  // Edges are suppressed until the pipeline has been refilled from the pins,
  // otherwise the reset-zero history would fake an edge on every high pin.
  assign armed = (arm_cnt_q == 2'(ARM_CYCLES));

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_det[i] = armed & edge_bit(sync_q[i], hist_q[i], EDGE_TYPE);
    end
  end

  assign sync_in = sync_q;

endmodule

// File: rtl/nios_system_pio_gen2.sv
// Avalon-MM parallel I/O port with edge capture and interrupt.
// Latency: write -> out_port/oe/irq 1 clk; read -> readdata 1 clk (held until next read).
// Backpressure: none; the slave never waits, every access completes in one cycle.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   address[2:0]          : word address (0 data, 1 direction, 2 irqmask,
//                           3 edgecapture, 4 outset, 5 outclear, 6-7 reserved)
//   chipselect, read_n,
//   write_n, writedata    : Avalon-MM slave access
//   readdata[31:0]        : registered read data, upper bits zero
//   in_port[WIDTH-1:0]    : asynchronous pins
//   out_port, oe          : output data and per-bit output enable
//   irq                   : registered interrupt request

module nios_system_pio_gen2
  import nios_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter int          IRQ_TYPE    = IRQ_LEVEL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VALUE);

  bus_req_t         req;
  logic [WIDTH-1:0] wd;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_det;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rd_word;
  logic [31:0]      readdata_q;
  logic             irq_q, irq_d;

  // Bus decode and data truncation to the port width.
  always_comb begin
    req.wr   = chipselect & ~write_n;
    req.rd   = chipselect & ~read_n;
    req.addr = address;
  end

  assign wd = writedata[WIDTH-1:0];

  // Bits of writedata above the port width are deliberately dropped.
  if (WIDTH < 32) begin : g_wd_hi
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[31:WIDTH];
  end

  nios_pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_in  (sync_in),
    .edge_det (edge_det)
  );

  // Register next-state. Edge capture is sticky; a write-1-to-clear is
  // applied before OR-ing in this cycle's edges so a coincident edge wins.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    ec_d   = ec_q | edge_det;
    if (req.wr) begin
      case (req.addr)
        ADDR_DATA:    data_d = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
        ADDR_EDGECAP: ec_d   = (ec_q & ~wd) | edge_det;
        ADDR_OUTSET:  data_d = data_q | wd;
        ADDR_OUTCLR:  data_d = data_q & ~wd;
        default:      ; // reserved: no state change
      endcase
    end
  end

  // Read mux. Set/clear strobes and reserved words read as zero.
  always_comb begin
    rd_val = '0;
    case (req.addr)
      ADDR_DATA:    rd_val = sync_in;
      ADDR_DIR:     rd_val = dir_q;
      ADDR_IRQMASK: rd_val = mask_q;
      ADDR_EDGECAP: rd_val = ec_q;
      default:      rd_val = '0;
    endcase
    rd_word              = '0;
    rd_word[WIDTH-1:0]   = rd_val;
  end

  // In edge mode irq follows the capture register's next value, so a clear
  // drops irq on the cycle right after the clearing write.
  always_comb begin
    if (IRQ_TYPE == IRQ_EDGE) begin
      irq_d = |(ec_d & mask_q);
    end else begin
      irq_d = |(sync_in & mask_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RST_DATA;
      dir_q      <= '0;
      mask_q     <= '0;
      ec_q       <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      ec_q   <= ec_d;
      irq_q  <= irq_d;
      // readdata only updates on a read and otherwise holds its last value.
      if (req.rd) begin
        readdata_q <= rd_word;
      end
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_pio_gen2.sv
module tb_nios_system_pio_gen2;
  import nios_pio_pkg::*;

  localparam int K_RD8 = 0, K_OUT8 = 1, K_OE8 = 2, K_IRQ8 = 3;
  localparam int K_RD32 = 4, K_OUT32 = 5, K_OE32 = 6, K_IRQ32 = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs8, cs32, read_n, write_n;
  logic [31:0] writedata;
  logic [31:0] readdata8, readdata32;
  logic [7:0]  in8, out8, oe8;
  logic [31:0] in32, out32, oe32;
  logic        irq8, irq32;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  nios_system_pio_gen2 #(.WIDTH(8), .RESET_VALUE(32'h3C), .EDGE_TYPE(EDGE_RISING),
                         .IRQ_TYPE(IRQ_EDGE)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata8), .in_port(in8), .out_port(out8), .oe(oe8), .irq(irq8));

  nios_system_pio_gen2 #(.WIDTH(32), .RESET_VALUE(32'h8000_0001), .EDGE_TYPE(EDGE_ANY),
                         .IRQ_TYPE(IRQ_LEVEL)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata32), .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void compare(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] sample(input int kind);
    logic [31:0] v;
    case (kind)
      K_RD8:   v = readdata8;
      K_OUT8:  v = 32'(out8);
      K_OE8:   v = 32'(oe8);
      K_IRQ8:  v = 32'(irq8);
      K_RD32:  v = readdata32;
      K_OUT32: v = out32;
      K_OE32:  v = oe32;
      default: v = 32'(irq32);
    endcase
    return v;
  endfunction

  // Schedule an expectation 'ofs' clock edges from now.
  task automatic expect_at(input int ofs, input int kind, input logic [31:0] e,
                           input string nm);
    exp_t it;
    it.due = cyc + ofs; it.kind = kind; it.exp = e; it.name = nm;
    exp_q.push_back(it);
  endtask

  // Monitor: on each falling edge, check every expectation due at this cycle.
  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due == cyc) begin
        compare(exp_q[i].name, sample(exp_q[i].kind), exp_q[i].exp);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit s32, input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0; cs8 = !s32; cs32 = s32;
    @(posedge clk); #1;
    write_n = 1'b1; cs8 = 1'b0; cs32 = 1'b0;
  endtask

  // A read is checked one edge later: readdata latency is exactly 1.
  task automatic rd(input bit s32, input logic [2:0] a, input logic [31:0] e,
                    input string nm);
    expect_at(1, s32 ? K_RD32 : K_RD8, e, nm);
    address = a; read_n = 1'b0; cs8 = !s32; cs32 = s32;
    @(posedge clk); #1;
    read_n = 1'b1; cs8 = 1'b0; cs32 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = '0; cs8 = 0; cs32 = 0; read_n = 1; write_n = 1;
    writedata = '0; in8 = '0; in32 = '0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    expect_at(1, K_OUT8, 32'h3C, "rst_out8");
    expect_at(1, K_OE8, 32'h0, "rst_oe8");
    expect_at(1, K_IRQ8, 32'h0, "rst_irq8");
    expect_at(1, K_OUT32, 32'h8000_0001, "rst_out32");
    expect_at(1, K_OE32, 32'h0, "rst_oe32");
    expect_at(1, K_IRQ32, 32'h0, "rst_irq32");
    for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'h0, $sformatf("rst_rd8_a%0d", a));

    // Data / set / clear sequence
    expect_at(1, K_OUT8, 32'hA5, "out_data_a5");
    wr(0, ADDR_DATA, 32'hA5);
    expect_at(1, K_OUT8, 32'hAF, "out_set_af");
    wr(0, ADDR_OUTSET, 32'h0F);
    expect_at(1, K_OUT8, 32'h2E, "out_clr_2e");
    wr(0, ADDR_OUTCLR, 32'h81);

    // Edge capture and edge-mode irq
    expect_at(1, K_IRQ8, 32'h0, "irq_before_edge");
    wr(0, ADDR_IRQMASK, 32'h04);
    in8 = 8'h04;
    expect_at(4, K_IRQ8, 32'h1, "irq_edge_within4");
    idle(4);
    rd(0, ADDR_EDGECAP, 32'h04, "ec_rise_bit2");
    rd(0, ADDR_DATA, 32'h04, "data_rd_sync");
    expect_at(1, K_IRQ8, 32'h0, "irq_after_clear");
    wr(0, ADDR_EDGECAP, 32'h04);
    rd(0, ADDR_EDGECAP, 32'h00, "ec_cleared");

    // Falling edge ignored; then new edge coincides with clear
    in8 = 8'h00;
    idle(5);
    rd(0, ADDR_EDGECAP, 32'h00, "ec_fall_ignored");
    in8 = 8'h04;
    idle(2);
    wr(0, ADDR_EDGECAP, 32'h04);
    rd(0, ADDR_EDGECAP, 32'h04, "ec_set_wins");
    expect_at(1, K_IRQ8, 32'h1, "irq_set_wins");

    // Upper writedata bits ignored
    expect_at(1, K_OE8, 32'h12, "oe8_trunc");
    wr(0, ADDR_DIR, 32'hFFFF_FF12);
    rd(0, ADDR_DIR, 32'h12, "dir8_rd_trunc");

    // 32-bit instance: full direction, reserved address, read hold
    expect_at(1, K_OE32, 32'hFFFF_FFFF, "oe32_all");
    wr(1, ADDR_DIR, 32'hFFFF_FFFF);
    rd(1, ADDR_DIR, 32'hFFFF_FFFF, "dir32_rd");
    rd(1, 3'd6, 32'h0, "rsv6_rd32_lat1");
    wr(1, 3'd7, 32'h1234_5678);
    rd(1, ADDR_DIR, 32'hFFFF_FFFF, "rsv7_wr_ignored");
    expect_at(2, K_RD32, 32'hFFFF_FFFF, "rd32_hold");
    expect_at(2, K_OUT32, 32'h8000_0001, "out32_unchanged");
    idle(2);

    // 32-bit level irq and any-edge capture
    wr(1, ADDR_IRQMASK, 32'h8000_0000);
    in32 = 32'h8000_0000;
    expect_at(4, K_IRQ32, 32'h1, "irq32_level_hi");
    idle(4);
    in32 = 32'h0;
    expect_at(4, K_IRQ32, 32'h0, "irq32_level_lo");
    idle(4);
    rd(1, ADDR_EDGECAP, 32'h8000_0000, "ec32_any");

    // Reset asserted mid-write
    idle(3);
    address = ADDR_DATA; writedata = 32'hFF; write_n = 1'b0; cs8 = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    compare("midrst_out8", 32'(out8), 32'h3C);
    compare("midrst_oe8", 32'(oe8), 32'h0);
    compare("midrst_irq8", 32'(irq8), 32'h0);
    compare("midrst_rd8", readdata8, 32'h0);
    compare("midrst_out32", out32, 32'h8000_0001);
    compare("midrst_oe32", oe32, 32'h0);
    @(posedge clk); #1;
    write_n = 1'b1; cs8 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_at(1, K_OUT8, 32'h3C, "midrst_no_update");
    idle(6);
    // in8[2] stayed high through reset: must not be captured as an edge.
    rd(0, ADDR_EDGECAP, 32'h0, "no_edge_after_reset");
    rd(0, ADDR_DIR, 32'h0, "dir_after_reset");

    idle(3);
    while (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected 0x%08h", exp_q[0].name, exp_q[0].exp);
      void'(exp_q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
